ahb_lite_traffic_gen: RTL and testbench

Parametrised, synthesizable AHB-Lite master that replaces hand-written read-loop tests with hardware-generated traffic. On start it issues NUM_XFERS single NONSEQ transfers to LFSR-derived addresses. Modes are read-only, write-only, or write-then-readback with data checking. It counts bus errors and data mismatches and reports pass/fail. It sits between the test harness and the AHB-Lite memory slave, in place of the interface transfer task.

---
 rtl/ahb_lite_traffic_gen.sv | 194 +++++++++++++++++++
 tb/tb_ahb_lite_traffic_gen.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_traffic_gen.sv
// AHB-Lite master generating LFSR-addressed single NONSEQ transfers, with
// optional write-then-readback data checking and ERROR-response retry.
module ahb_lite_traffic_gen #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_XFERS   = 20,
  parameter logic [15:0] ADDR_OFFSET = 16'd4,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] HADDR,
  output logic              HWRITE,
  output logic [1:0]        HTRANS,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count
);

  localparam int unsigned LSB       = $clog2(DATA_W / 8);
  localparam logic [2:0]  SIZE      = 3'(LSB);
  localparam logic [15:0] LAST      = 16'(NUM_XFERS - 1);
  localparam logic [1:0]  TR_IDLE   = 2'b00;
  localparam logic [1:0]  TR_NONSEQ = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_DRAIN, S_DONE} state_t;

  state_t              state;
  logic                readback;
  logic [15:0]         lfsr;
  logic [15:0]         lfsr_nxt;
  logic [15:0]         cnt;
  logic                dp_valid;
  logic                dp_write;
  logic                dp_check;
  logic [ADDR_W-1:0]   dp_addr;
  logic                retry_pend;
  logic                retry_issued;
  logic                mismatch;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  function automatic logic [ADDR_W-1:0] addr_of(input logic [15:0] v);
    logic [15:0]       s;
    logic [ADDR_W-1:0] a;
    s = v + ADDR_OFFSET;
    s[LSB-1:0] = '0;
    a = '0;
    a[15:0] = s;
    return a;
  endfunction

  function automatic logic [DATA_W-1:0] pattern_of(input logic [ADDR_W-1:0] a);
    return {(DATA_W / 16){a[15:0] ^ 16'h5A5A}};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  assign HBURST = 3'b000;
  assign HPROT  = 4'b0001;

  always_comb begin
    lfsr_nxt = lfsr_step(lfsr);
    mismatch = dp_valid && dp_check && HREADY && !HRESP &&
               (HRDATA != pattern_of(dp_addr));
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state        <= S_IDLE;
      readback     <= 1'b0;
      lfsr         <= LFSR_SEED;
      cnt          <= '0;
      dp_valid     <= 1'b0;
      dp_write     <= 1'b0;
      dp_check     <= 1'b0;
      dp_addr      <= '0;
      retry_pend   <= 1'b0;
      retry_issued <= 1'b0;
      HADDR        <= '0;
      HWRITE       <= 1'b0;
      HTRANS       <= TR_IDLE;
      HSIZE        <= '0;
      HWDATA       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_count    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state        <= (mode == 2'd1 || mode == 2'd2) ? S_WR : S_RD;
            readback     <= (mode == 2'd2);
            lfsr         <= LFSR_SEED;
            cnt          <= '0;
            dp_valid     <= 1'b0;
            retry_pend   <= 1'b0;
            retry_issued <= 1'b0;
            HADDR        <= addr_of(LFSR_SEED);
            HWRITE       <= (mode == 2'd1 || mode == 2'd2);
            HTRANS       <= TR_NONSEQ;
            HSIZE        <= SIZE;
            busy         <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_count    <= '0;
          end
        end
        default: begin
          if (!HREADY) begin
            // First ERROR cycle: count it and cancel whatever address is pending.
            if (HRESP && dp_valid && !retry_pend) begin
              err_count  <= sat_inc(err_count);
              HTRANS     <= TR_IDLE;
              HSIZE      <= '0;
              retry_pend <= 1'b1;
            end
          end else if (retry_pend) begin
            // Second ERROR cycle: re-issue the failed transfer; the cancelled
            // address is still addr_of(lfsr) and is presented after the retry.
            retry_pend   <= 1'b0;
            retry_issued <= 1'b1;
            dp_valid     <= 1'b0;
            HADDR        <= dp_addr;
            HWRITE       <= dp_write;
            HTRANS       <= TR_NONSEQ;
            HSIZE        <= SIZE;
          end else begin
            if (mismatch) err_count <= sat_inc(err_count);
            if (HTRANS == TR_NONSEQ) begin
              dp_valid     <= 1'b1;
              dp_write     <= HWRITE;
              dp_check     <= readback && !HWRITE;
              dp_addr      <= HADDR;
              HWDATA       <= HWRITE ? pattern_of(HADDR) : '0;
              retry_issued <= 1'b0;
              if (retry_issued) begin
                if (state == S_DRAIN) begin
                  HTRANS <= TR_IDLE;
                  HSIZE  <= '0;
                  HADDR  <= '0;
                  HWRITE <= 1'b0;
                end else begin
                  HADDR  <= addr_of(lfsr);
                  HWRITE <= (state == S_WR);
                end
              end else if (cnt != LAST) begin
                lfsr  <= lfsr_nxt;
                cnt   <= cnt + 16'd1;
                HADDR <= addr_of(lfsr_nxt);
              end else if (state == S_WR && readback) begin
                state  <= S_RD;
                lfsr   <= LFSR_SEED;
                cnt    <= '0;
                HADDR  <= addr_of(LFSR_SEED);
                HWRITE <= 1'b0;
              end else begin
                state  <= S_DRAIN;
                HTRANS <= TR_IDLE;
                HSIZE  <= '0;
                HADDR  <= '0;
                HWRITE <= 1'b0;
              end
            end else begin
              dp_valid <= 1'b0;
              if (state == S_DRAIN) begin
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= (err_count == 16'd0) && !mismatch;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_lite_traffic_gen.sv
// Scoreboard bench for ahb_lite_traffic_gen: a memory slave with random waits,
// error injection and read corruption checks bus traffic against a model.
module tb_ahb_lite_traffic_gen;

  localparam int N = 20;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        start;
  logic [1:0]  mode;
  logic [15:0] HADDR;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] err_count;

  ahb_lite_traffic_gen #(
    .ADDR_W(16), .DATA_W(32), .NUM_XFERS(N),
    .ADDR_OFFSET(16'd4), .LFSR_SEED(16'hACE1)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .mode(mode),
    .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count)
  );

  always #5 HCLK = ~HCLK;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: k-th address of a phase and the data stored there.
  function automatic logic [15:0] model_addr(input int k);
    int s;
    int fb;
    s = 'hACE1;
    for (int i = 0; i < k; i++) begin
      fb = (s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 1;
      s  = (s >> 1) | (fb << 15);
    end
    return 16'((((s + 4) % 65536) / 4) * 4);
  endfunction

  function automatic logic [31:0] model_data(input logic [15:0] a);
    logic [15:0] p;
    p = a ^ 16'h5A5A;
    return {p, p};
  endfunction

  typedef struct packed { logic [15:0] addr; logic write; } exp_t;
  exp_t sbq[$];

  task automatic push_phase(input logic wr, input int dup);
    exp_t e;
    for (int k = 0; k < N; k++) begin
      e.addr  = model_addr(k);
      e.write = wr;
      sbq.push_back(e);
      if (k == dup) sbq.push_back(e);
    end
  endtask

  // Slave knobs and run counters
  int max_wait = 0;
  int err_idx = -1;
  int corrupt_read = -1;
  int acc_cnt = 0;
  int rd_cnt = 0;

  logic [31:0] mem [logic [15:0]];
  logic        dp_valid = 1'b0;
  logic        dp_write = 1'b0;
  logic        dp_err = 1'b0;
  logic        prev_hold = 1'b0;
  logic [15:0] dp_addr = '0;
  int          waits = 0;
  int          err_st = 0;
  logic [15:0] h_addr;
  logic [1:0]  h_trans;
  logic        h_write;
  logic [31:0] h_wdata;

  initial begin : slave
    logic        rdy;
    logic        rsp;
    logic        ok;
    logic [31:0] rdata;
    exp_t        e;
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = '0;
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        dp_valid = 1'b0; err_st = 0; prev_hold = 1'b0;
        HREADY = 1'b1; HRESP = 1'b0;
        continue;
      end
      if (prev_hold) begin
        check("hold_haddr", HADDR, h_addr);
        check("hold_htrans", HTRANS, h_trans);
        check("hold_hwrite", HWRITE, h_write);
        check("hold_hwdata", HWDATA, h_wdata);
      end
      rdy = 1'b1; rsp = 1'b0; ok = 1'b0; rdata = '0;
      if (dp_valid) begin
        if (err_st == 1) begin
          rsp = 1'b1; err_st = 0;
          check("cancel_htrans", HTRANS, 2'b00);
        end else if (waits > 0) begin
          rdy = 1'b0; waits--;
        end else if (dp_err) begin
          rdy = 1'b0; rsp = 1'b1; err_st = 1; dp_err = 1'b0;
        end else begin
          ok = 1'b1;
        end
      end
      if (ok) begin
        if (dp_write) begin
          check("hwdata", HWDATA, model_data(dp_addr));
          mem[dp_addr] = HWDATA;
        end else begin
          rdata = mem.exists(dp_addr) ? mem[dp_addr] : 32'h0;
          if (rd_cnt == corrupt_read) rdata[0] = ~rdata[0];
          rd_cnt++;
        end
      end
      HREADY = rdy; HRESP = rsp; HRDATA = rdata;
      prev_hold = !rdy && !rsp;
      h_addr = HADDR; h_trans = HTRANS; h_write = HWRITE; h_wdata = HWDATA;
      if (rdy) begin
        if (HTRANS == 2'b10) begin
          check("sb_nonempty", 64'(sbq.size() != 0), 1);
          if (sbq.size() != 0) begin
            e = sbq.pop_front();
            check("haddr", HADDR, e.addr);
            check("hwrite", HWRITE, e.write);
            check("hsize", HSIZE, 3'd2);
          end else begin
            e.addr = HADDR;
          end
          dp_valid = 1'b1;
          dp_addr  = e.addr;
          dp_write = HWRITE;
          waits    = (max_wait > 0) ? int'($urandom_range(max_wait, 0)) : 0;
          dp_err   = (acc_cnt == err_idx);
          acc_cnt++;
        end else begin
          dp_valid = 1'b0;
        end
      end
    end
  end

  task automatic run(input logic [1:0] m, input int exp_cycles, input logic [15:0] exp_err,
                     input int poke_at, input string tag);
    int cyc;
    cyc = 0;
    acc_cnt = 0;
    rd_cnt = 0;
    @(negedge HCLK);
    mode = m; start = 1'b1;
    @(negedge HCLK);
    start = 1'b0;
    check({tag, "_busy_start"}, busy, 1);
    check({tag, "_first_addr"}, HADDR, 16'hACE4);
    check({tag, "_first_trans"}, HTRANS, 2'b10);
    check({tag, "_first_write"}, HWRITE, (m == 2'd1 || m == 2'd2));
    check({tag, "_hburst"}, HBURST, 3'b000);
    check({tag, "_hprot"}, HPROT, 4'b0001);
    while (!done && cyc < 2000) begin
      @(negedge HCLK);
      cyc++;
      if (poke_at > 0 && cyc == poke_at) begin
        start = 1'b1; mode = 2'd1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, "_done"}, done, 1);
    if (exp_cycles > 0) check({tag, "_cycles"}, cyc, exp_cycles);
    check({tag, "_err_count"}, err_count, exp_err);
    check({tag, "_pass"}, pass, (exp_err == 16'd0));
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_sb_drained"}, sbq.size(), 0);
  endtask

  initial begin : stim
    int guard;
    HRESET = 1'b1; start = 1'b0; mode = 2'd0;
    repeat (3) @(negedge HCLK);
    check("rst_htrans", HTRANS, 2'b00);
    check("rst_haddr", HADDR, 16'h0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    HRESET = 1'b0;

    push_phase(1'b1, -1);
    run(2'd1, N + 1, 16'd0, 0, "wr_only");

    push_phase(1'b1, -1); push_phase(1'b0, -1);
    run(2'd2, 2 * N + 1, 16'd0, 0, "readback");

    corrupt_read = 4;
    push_phase(1'b1, -1); push_phase(1'b0, -1);
    run(2'd2, 2 * N + 1, 16'd1, 0, "corrupt");
    corrupt_read = -1;

    max_wait = 3;
    push_phase(1'b1, -1); push_phase(1'b0, -1);
    run(2'd2, 0, 16'd0, 7, "waits");
    max_wait = 0;

    err_idx = 2;
    push_phase(1'b1, 2);
    run(2'd1, 0, 16'd1, 0, "error_retry");
    err_idx = -1;

    push_phase(1'b0, -1);
    run(2'd3, N + 1, 16'd0, 0, "reserved_mode");

    // Async reset part-way through the read phase, after a mismatch was counted
    corrupt_read = 1;
    acc_cnt = 0; rd_cnt = 0;
    push_phase(1'b1, -1); push_phase(1'b0, -1);
    @(negedge HCLK);
    mode = 2'd2; start = 1'b1;
    @(negedge HCLK);
    start = 1'b0;
    guard = 0;
    while (acc_cnt < N + 6 && guard < 500) begin
      @(negedge HCLK);
      guard++;
    end
    check("midrd_reached", 64'(acc_cnt >= N + 6), 1);
    check("midrd_err_before", err_count, 16'd1);
    #2 HRESET = 1'b1;
    #1;
    check("midrd_htrans", HTRANS, 2'b00);
    check("midrd_busy", busy, 0);
    check("midrd_err", err_count, 0);
    check("midrd_done", done, 0);
    sbq.delete();
    corrupt_read = -1;
    @(negedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    push_phase(1'b1, -1);
    run(2'd1, N + 1, 16'd0, 0, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
